// File: rtl/multicycle_controller.sv
// Moore-style control FSM for the multicycle RV32I core: sequences the shared
// datapath and drives its mux selects, write enables, ALUControl and ImmSrc.
module multicycle_controller (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       zero_i,
  output logic       pc_write_o,
  output logic       adr_src_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_write_o,
  output logic [1:0] result_src_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] alu_control_o,
  output logic [1:0] imm_src_o
);

  localparam int unsigned OP_W = 7;

  localparam logic [OP_W-1:0] OP_LW   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW   = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R    = 7'b0110011;
  localparam logic [OP_W-1:0] OP_IALU = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BEQ  = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_TARGET    = 4'd2,
    S_MEM_ADR   = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXEC_R    = 4'd7,
    S_EXEC_I    = 4'd8,
    S_ALU_WB    = 4'd9,
    S_BEQ       = 4'd10,
    S_JAL       = 4'd11
  } state_t;

  state_t     state_q, state_d;
  logic       pc_update, branch;
  logic       mem_write_s, ir_write_s, reg_write_s;
  logic [1:0] alu_op;

  // State register; reset abandons any in-flight instruction
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_FETCH;
    else         state_q <= state_d;
  end

  // Next state and per-state datapath controls
  always_comb begin
    state_d      = state_q;
    pc_update    = 1'b0;
    branch       = 1'b0;
    adr_src_o    = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    result_src_o = 2'b00;
    alu_src_a_o  = 2'b00;
    alu_src_b_o  = 2'b00;
    alu_op       = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        ir_write_s   = 1'b1;
        alu_src_b_o  = 2'b10;
        result_src_o = 2'b10;
        pc_update    = 1'b1;
        state_d      = S_DECODE;
      end
      S_DECODE: begin
        if (op_i == OP_LW || op_i == OP_SW)       state_d = S_MEM_ADR;
        else if (op_i == OP_R)                    state_d = S_EXEC_R;
        else if (op_i == OP_IALU)                 state_d = S_EXEC_I;
        else if (op_i == OP_BEQ || op_i == OP_JAL) state_d = S_TARGET;
        else                                      state_d = S_FETCH;
      end
      S_TARGET: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
        state_d     = (op_i == OP_BEQ) ? S_BEQ : S_JAL;
      end
      S_MEM_ADR: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        state_d     = (op_i == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        adr_src_o = 1'b1;
        state_d   = S_MEM_WB;
      end
      S_MEM_WB: begin
        result_src_o = 2'b01;
        reg_write_s  = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_WRITE: begin
        adr_src_o   = 1'b1;
        mem_write_s = 1'b1;
        state_d     = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a_o = 2'b10;
        alu_op      = 2'b10;
        state_d     = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        alu_op      = 2'b10;
        state_d     = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_s = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a_o = 2'b10;
        alu_op      = 2'b01;
        branch      = 1'b1;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        pc_update   = 1'b1;
        state_d     = S_ALU_WB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Write enables are suppressed for as long as reset is held
  always_comb begin
    pc_write_o  = (pc_update | (branch & zero_i)) & ~reset_i;
    mem_write_o = mem_write_s & ~reset_i;
    ir_write_o  = ir_write_s & ~reset_i;
    reg_write_o = reg_write_s & ~reset_i;
  end

  // ALU decoder
  always_comb begin
    alu_control_o = 3'b000;
    unique case (alu_op)
      2'b01: alu_control_o = 3'b001;
      2'b10: begin
        unique case (funct3_i)
          3'b000:  alu_control_o = (op_i[5] & funct7b5_i) ? 3'b001 : 3'b000;
          3'b010:  alu_control_o = 3'b101;
          3'b110:  alu_control_o = 3'b011;
          3'b111:  alu_control_o = 3'b010;
          default: alu_control_o = 3'b000;
        endcase
      end
      default: alu_control_o = 3'b000;
    endcase
  end

  // Immediate format follows Op so Extend captures it during Decode
  always_comb begin
    imm_src_o = 2'b00;
    if (op_i == OP_SW)       imm_src_o = 2'b01;
    else if (op_i == OP_BEQ) imm_src_o = 2'b10;
    else if (op_i == OP_JAL) imm_src_o = 2'b11;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle expected control
// vectors are queued with their stimulus and compared as the FSM steps.
module tb_multicycle_controller;

  typedef enum int {
    FETCH, DECODE, TARGET, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BEQ, JAL
  } st_t;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic [15:0] exp;
    string       tag;
  } ent_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;

  int   vectors = 0;
  int   miscompares = 0;
  ent_t sbq[$];

  multicycle_controller dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .op_i         (op),
    .funct3_i     (funct3),
    .funct7b5_i   (funct7b5),
    .zero_i       (zero),
    .pc_write_o   (pc_write),
    .adr_src_o    (adr_src),
    .mem_write_o  (mem_write),
    .ir_write_o   (ir_write),
    .reg_write_o  (reg_write),
    .result_src_o (result_src),
    .alu_src_a_o  (alu_src_a),
    .alu_src_b_o  (alu_src_b),
    .alu_control_o(alu_control),
    .imm_src_o    (imm_src)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] observed();
    return {pc_write, adr_src, mem_write, ir_write, reg_write,
            result_src, alu_src_a, alu_src_b, alu_control, imm_src};
  endfunction

  // Reference control vector for one state; alu_ex is the ALUControl the
  // test expects during an Execute state.
  function automatic logic [15:0] exp_vec(st_t s, logic [6:0] o, logic z, logic [2:0] alu_ex);
    logic       pcw, adr, memw, irw, regw;
    logic [1:0] res, sa, sb, imm;
    logic [2:0] alu;
    {pcw, adr, memw, irw, regw} = 5'b0;
    res = 2'b00; sa = 2'b00; sb = 2'b00; alu = 3'b000;
    case (s)
      FETCH:    begin irw = 1'b1; sb = 2'b10; res = 2'b10; pcw = 1'b1; end
      TARGET:   begin sa = 2'b01; sb = 2'b01; end
      MEMADR:   begin sa = 2'b10; sb = 2'b01; end
      MEMREAD:  adr = 1'b1;
      MEMWB:    begin res = 2'b01; regw = 1'b1; end
      MEMWRITE: begin adr = 1'b1; memw = 1'b1; end
      EXECR:    begin sa = 2'b10; alu = alu_ex; end
      EXECI:    begin sa = 2'b10; sb = 2'b01; alu = alu_ex; end
      ALUWB:    regw = 1'b1;
      BEQ:      begin sa = 2'b10; alu = 3'b001; pcw = z; end
      JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
      default:  ;
    endcase
    if (o == OP_SW)       imm = 2'b01;
    else if (o == OP_BEQ) imm = 2'b10;
    else if (o == OP_JAL) imm = 2'b11;
    else                  imm = 2'b00;
    return {pcw, adr, memw, irw, regw, res, sa, sb, alu, imm};
  endfunction

  task automatic push_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input logic z, input logic [2:0] alu_ex, input string tag,
                            input st_t seq[5], input int n);
    for (int i = 0; i < n; i++) begin
      ent_t e;
      e.op  = o;
      e.f3  = f3;
      e.f7  = f7;
      e.z   = z;
      e.exp = exp_vec(seq[i], o, z, alu_ex);
      e.tag = $sformatf("%s/%s", tag, seq[i].name());
      sbq.push_back(e);
    end
  endtask

  task automatic test_reset();
    logic [15:0] got;
    reset = 1'b1; op = OP_BAD; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if ({pc_write, mem_write, ir_write, reg_write} !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_we cyc%0d: got %b expected 0000", c,
                 {pc_write, mem_write, ir_write, reg_write});
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    op = OP_LW;
    @(negedge clk);
    got = observed();
    vectors++;
    if (got !== exp_vec(FETCH, OP_LW, 1'b1, 3'b000)) begin
      miscompares++;
      $display("FAIL reset_fetch: got %h expected %h", got, exp_vec(FETCH, OP_LW, 1'b1, 3'b000));
    end
    @(posedge clk); #1;
    // Finish the lw whose Fetch was just observed
    push_instr(OP_LW, 3'b010, 1'b0, 1'b1, 3'b000, "lw0",
               '{DECODE, MEMADR, MEMREAD, MEMWB, FETCH}, 4);
  endtask

  task automatic test_load_store();
    ent_t e; logic [15:0] got;
    push_instr(OP_LW, 3'b010, 1'b0, 1'b1, 3'b000, "lw",
               '{FETCH, DECODE, MEMADR, MEMREAD, MEMWB}, 5);
    push_instr(OP_SW, 3'b010, 1'b1, 1'b1, 3'b000, "sw",
               '{FETCH, DECODE, MEMADR, MEMWRITE, FETCH}, 4);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      op = e.op; funct3 = e.f3; funct7b5 = e.f7; zero = e.z;
      @(negedge clk);
      got = observed();
      vectors++;
      if (got !== e.exp) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.tag, got, e.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_store();
    ent_t e; logic [15:0] got, want;
    push_instr(OP_SW, 3'b010, 1'b0, 1'b0, 3'b000, "sw_pre",
               '{FETCH, DECODE, MEMADR, FETCH, FETCH}, 3);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      op = e.op; funct3 = e.f3; funct7b5 = e.f7; zero = e.z;
      @(negedge clk);
      got = observed();
      vectors++;
      if (got !== e.exp) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.tag, got, e.exp);
      end
      @(posedge clk); #1;
    end
    // FSM now sits in MemWrite; reset must swallow the store
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if ({pc_write, mem_write, ir_write, reg_write} !== 4'b0000) begin
        miscompares++;
        $display("FAIL midrst_we cyc%0d: got %b expected 0000", c,
                 {pc_write, mem_write, ir_write, reg_write});
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    want = exp_vec(FETCH, OP_SW, 1'b0, 3'b000);
    @(negedge clk);
    got = observed();
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL midrst_fetch: got %h expected %h", got, want);
    end
    @(posedge clk); #1;
    push_instr(OP_SW, 3'b010, 1'b0, 1'b0, 3'b000, "sw_post",
               '{DECODE, MEMADR, MEMWRITE, FETCH, FETCH}, 3);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      op = e.op; funct3 = e.f3; funct7b5 = e.f7; zero = e.z;
      @(negedge clk);
      got = observed();
      vectors++;
      if (got !== e.exp) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.tag, got, e.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    ent_t e; logic [15:0] got;
    push_instr(OP_BEQ, 3'b000, 1'b0, 1'b1, 3'b000, "beq_taken",
               '{FETCH, DECODE, TARGET, BEQ, FETCH}, 4);
    push_instr(OP_BEQ, 3'b000, 1'b0, 1'b0, 3'b000, "beq_not",
               '{FETCH, DECODE, TARGET, BEQ, FETCH}, 4);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      op = e.op; funct3 = e.f3; funct7b5 = e.f7; zero = e.z;
      @(negedge clk);
      got = observed();
      vectors++;
      if (got !== e.exp) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.tag, got, e.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu_decode();
    ent_t e; logic [15:0] got;
    push_instr(OP_R,    3'b000, 1'b1, 1'b1, 3'b001, "sub",
               '{FETCH, DECODE, EXECR, ALUWB, FETCH}, 4);
    push_instr(OP_IALU, 3'b000, 1'b1, 1'b1, 3'b000, "addi",
               '{FETCH, DECODE, EXECI, ALUWB, FETCH}, 4);
    push_instr(OP_R,    3'b000, 1'b0, 1'b0, 3'b000, "add",
               '{FETCH, DECODE, EXECR, ALUWB, FETCH}, 4);
    push_instr(OP_R,    3'b111, 1'b0, 1'b1, 3'b010, "and",
               '{FETCH, DECODE, EXECR, ALUWB, FETCH}, 4);
    push_instr(OP_IALU, 3'b010, 1'b0, 1'b1, 3'b101, "slti",
               '{FETCH, DECODE, EXECI, ALUWB, FETCH}, 4);
    push_instr(OP_R,    3'b110, 1'b0, 1'b0, 3'b011, "or",
               '{FETCH, DECODE, EXECR, ALUWB, FETCH}, 4);
    push_instr(OP_R,    3'b001, 1'b1, 1'b0, 3'b000, "sll_unimpl",
               '{FETCH, DECODE, EXECR, ALUWB, FETCH}, 4);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      op = e.op; funct3 = e.f3; funct7b5 = e.f7; zero = e.z;
      @(negedge clk);
      got = observed();
      vectors++;
      if (got !== e.exp) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.tag, got, e.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jump_illegal();
    ent_t e; logic [15:0] got;
    push_instr(OP_JAL, 3'b000, 1'b0, 1'b0, 3'b000, "jal",
               '{FETCH, DECODE, TARGET, JAL, ALUWB}, 5);
    push_instr(OP_BAD, 3'b000, 1'b1, 1'b1, 3'b000, "illegal",
               '{FETCH, DECODE, FETCH, FETCH, FETCH}, 2);
    push_instr(OP_SW,  3'b010, 1'b0, 1'b1, 3'b000, "sw_after",
               '{FETCH, DECODE, MEMADR, MEMWRITE, FETCH}, 5);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      op = e.op; funct3 = e.f3; funct7b5 = e.f7; zero = e.z;
      @(negedge clk);
      got = observed();
      vectors++;
      if (got !== e.exp) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.tag, got, e.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_load_store();
    test_reset_mid_store();
    test_branch();
    test_alu_decode();
    test_jump_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
